// File: rtl/issue_hazard_ctrl.sv
// In-order issue slot in front of the register scoreboard.
// Stalls on RAW hazards, selects forwarding, and claims destinations on issue.
module issue_hazard_ctrl #(
  parameter int         PAYLOAD_W = 32,
  parameter logic [3:0] FWD_MASK  = 4'b1111
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [4:0]           in_src_a,
  input  logic [4:0]           in_src_b,
  input  logic                 in_use_a,
  input  logic                 in_use_b,
  input  logic [4:0]           in_dst_a,
  input  logic [4:0]           in_dst_b,
  input  logic                 in_we_a,
  input  logic                 in_we_b,
  input  logic [1:0]           in_unit,
  input  logic                 flush,
  output logic [4:0]           sb_addr_a,
  output logic [4:0]           sb_addr_b,
  input  logic                 sb_pending_a,
  input  logic                 sb_pending_b,
  input  logic [1:0]           sb_unit_a,
  input  logic [1:0]           sb_unit_b,
  input  logic [4:0]           sb_row_a,
  input  logic [4:0]           sb_row_b,
  output logic [1:0]           sb_registerunit,
  output logic [4:0]           sb_writeaddr_a,
  output logic [4:0]           sb_writeaddr_b,
  output logic                 sb_enablewrite_a,
  output logic                 sb_enablewrite_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           out_unit,
  output logic                 out_fwd_a,
  output logic                 out_fwd_b,
  output logic [15:0]          stall_cycles
);

  typedef enum logic {EMPTY, HELD} state_t;

  state_t state, state_nx;

  logic [PAYLOAD_W-1:0] s_payload;
  logic [4:0] s_src_a, s_src_b;
  logic [4:0] s_dst_a, s_dst_b;
  logic       s_use_a, s_use_b;
  logic       s_we_a, s_we_b;
  logic [1:0] s_unit;

  logic fwd_ok_a, fwd_ok_b;
  logic live_a, live_b;
  logic haz_a, haz_b;
  logic fwd_a, fwd_b;
  logic out_free, issue, accept;

  // unit/row are only meaningful while pending; gate them before use
  assign fwd_ok_a = sb_pending_a ?
    (sb_row_a == 5'b00001 && FWD_MASK[sb_unit_a]) : 1'b0;
  assign fwd_ok_b = sb_pending_b ?
    (sb_row_b == 5'b00001 && FWD_MASK[sb_unit_b]) : 1'b0;

  assign live_a = s_use_a && (s_src_a != 5'd0) && sb_pending_a;
  assign live_b = s_use_b && (s_src_b != 5'd0) && sb_pending_b;
  assign haz_a  = live_a && !fwd_ok_a;
  assign haz_b  = live_b && !fwd_ok_b;
  assign fwd_a  = live_a && fwd_ok_a;
  assign fwd_b  = live_b && fwd_ok_b;

  assign out_free = !out_valid || out_ready;
  assign issue    = (state == HELD) && !haz_a && !haz_b
                    && out_free && !flush;
  assign accept   = in_valid && in_ready;

  assign sb_addr_a       = s_src_a;
  assign sb_addr_b       = s_src_b;
  assign sb_writeaddr_a  = s_dst_a;
  assign sb_writeaddr_b  = s_dst_b;
  assign sb_registerunit = s_unit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush)       state_nx = EMPTY;
    else if (accept) state_nx = HELD;
    else if (issue)  state_nx = EMPTY;
  end

  always_comb begin
    in_ready         = 1'b0;
    sb_enablewrite_a = 1'b0;
    sb_enablewrite_b = 1'b0;
    in_ready         = ((state == EMPTY) || issue) && !flush;
    sb_enablewrite_a = issue && s_we_a && (s_dst_a != 5'd0);
    sb_enablewrite_b = issue && s_we_b && (s_dst_b != 5'd0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_payload <= '0;
      s_src_a   <= '0;
      s_src_b   <= '0;
      s_dst_a   <= '0;
      s_dst_b   <= '0;
      s_use_a   <= 1'b0;
      s_use_b   <= 1'b0;
      s_we_a    <= 1'b0;
      s_we_b    <= 1'b0;
      s_unit    <= '0;
    end else if (accept) begin
      s_payload <= in_payload;
      s_src_a   <= in_src_a;
      s_src_b   <= in_src_b;
      s_dst_a   <= in_dst_a;
      s_dst_b   <= in_dst_b;
      s_use_a   <= in_use_a;
      s_use_b   <= in_use_b;
      s_we_a    <= in_we_a;
      s_we_b    <= in_we_b;
      s_unit    <= in_unit;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
      out_unit    <= '0;
      out_fwd_a   <= 1'b0;
      out_fwd_b   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid   <= 1'b1;
      out_payload <= s_payload;
      out_unit    <= s_unit;
      out_fwd_a   <= fwd_a;
      out_fwd_b   <= fwd_b;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_cycles <= '0;
    else if ((state == HELD) && !issue && !flush
             && (stall_cycles != 16'hFFFF))
      stall_cycles <= stall_cycles + 16'd1;
  end

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Directed bench for issue_hazard_ctrl; instance 0 forwards from all units,
// instance 1 cannot forward from unit 1.
module tb_issue_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_payload = '0;
  logic [4:0]  in_src_a = '0, in_src_b = '0;
  logic        in_use_a = 1'b0, in_use_b = 1'b0;
  logic [4:0]  in_dst_a = '0, in_dst_b = '0;
  logic        in_we_a = 1'b0, in_we_b = 1'b0;
  logic [1:0]  in_unit = '0;
  logic        flush = 1'b0;
  logic        sb_pending_a = 1'b0, sb_pending_b = 1'b0;
  logic [1:0]  sb_unit_a = 'x, sb_unit_b = 'x;
  logic [4:0]  sb_row_a = 'x, sb_row_b = 'x;
  logic        out_ready = 1'b1;

  logic [1:0]  in_ready, en_a, en_b, out_valid, fwd_a, fwd_b;
  logic [4:0]  addr_a [2];
  logic [4:0]  addr_b [2];
  logic [4:0]  waddr_a [2];
  logic [4:0]  waddr_b [2];
  logic [1:0]  regunit [2];
  logic [31:0] out_payload [2];
  logic [1:0]  out_unit [2];
  logic [15:0] stall [2];

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    issue_hazard_ctrl #(
      .PAYLOAD_W(32),
      .FWD_MASK (g == 0 ? 4'b1111 : 4'b1101)
    ) dut (
      .clock           (clock),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready[g]),
      .in_payload      (in_payload),
      .in_src_a        (in_src_a),
      .in_src_b        (in_src_b),
      .in_use_a        (in_use_a),
      .in_use_b        (in_use_b),
      .in_dst_a        (in_dst_a),
      .in_dst_b        (in_dst_b),
      .in_we_a         (in_we_a),
      .in_we_b         (in_we_b),
      .in_unit         (in_unit),
      .flush           (flush),
      .sb_addr_a       (addr_a[g]),
      .sb_addr_b       (addr_b[g]),
      .sb_pending_a    (sb_pending_a),
      .sb_pending_b    (sb_pending_b),
      .sb_unit_a       (sb_unit_a),
      .sb_unit_b       (sb_unit_b),
      .sb_row_a        (sb_row_a),
      .sb_row_b        (sb_row_b),
      .sb_registerunit (regunit[g]),
      .sb_writeaddr_a  (waddr_a[g]),
      .sb_writeaddr_b  (waddr_b[g]),
      .sb_enablewrite_a(en_a[g]),
      .sb_enablewrite_b(en_b[g]),
      .out_valid       (out_valid[g]),
      .out_ready       (out_ready),
      .out_payload     (out_payload[g]),
      .out_unit        (out_unit[g]),
      .out_fwd_a       (fwd_a[g]),
      .out_fwd_b       (fwd_b[g]),
      .stall_cycles    (stall[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] p,
                     input logic [4:0] sa, input logic ua,
                     input logic [4:0] sbr, input logic ub,
                     input logic [4:0] da, input logic wa,
                     input logic [4:0] db, input logic wb,
                     input logic [1:0] u);
    in_valid = v;   in_payload = p;
    in_src_a = sa;  in_use_a = ua;
    in_src_b = sbr; in_use_b = ub;
    in_dst_a = da;  in_we_a = wa;
    in_dst_b = db;  in_we_b = wb;
    in_unit  = u;
  endtask

  task automatic sba(input logic p, input logic [1:0] u,
                     input logic [4:0] r);
    sb_pending_a = p;
    if (p) begin sb_unit_a = u;  sb_row_a = r;  end
    else   begin sb_unit_a = 'x; sb_row_a = 'x; end
  endtask

  task automatic sbb(input logic p, input logic [1:0] u,
                     input logic [4:0] r);
    sb_pending_b = p;
    if (p) begin sb_unit_b = u;  sb_row_b = r;  end
    else   begin sb_unit_b = 'x; sb_row_b = 'x; end
  endtask

  initial begin
    logic [4:0] rows [4];
    rows[0] = 5'b10000; rows[1] = 5'b01000;
    rows[2] = 5'b00100; rows[3] = 5'b00010;

    // reset held low
    #2;
    for (int g = 0; g < 2; g++) begin
      chk("rst_in_ready", in_ready[g], 1);
      chk("rst_out_valid", out_valid[g], 0);
      chk("rst_payload", out_payload[g], 0);
      chk("rst_stall", stall[g], 0);
      chk("rst_en_a", en_a[g], 0);
    end
    tick();
    reset = 1'b1;

    // independent stream r1, r2, r3
    put(1, 32'h11, 0, 0, 0, 0, 5'd1, 1, 0, 0, 2'd0);
    #1 chk("a_in_ready", in_ready[0], 1);
    tick();
    put(1, 32'h22, 0, 0, 0, 0, 5'd2, 1, 0, 0, 2'd0);
    #1 chk("a_en1", en_a[0], 1);
    chk("a_waddr1", waddr_a[0], 1);
    chk("a_accept2", in_ready[0], 1);
    tick();
    put(1, 32'h33, 0, 0, 0, 0, 5'd3, 1, 0, 0, 2'd0);
    #1 chk("a_valid1", out_valid[0], 1);
    chk("a_pay1", out_payload[0], 32'h11);
    chk("a_en2", en_a[0], 1);
    chk("a_waddr2", waddr_a[0], 2);
    tick();
    in_valid = 1'b0;
    #1 chk("a_pay2", out_payload[0], 32'h22);
    chk("a_en3", en_a[0], 1);
    chk("a_waddr3", waddr_a[0], 3);
    chk("a_fwd2", fwd_a[0], 0);
    tick();
    #1 chk("a_pay3", out_payload[0], 32'h33);
    chk("a_en_idle", en_a[0], 0);
    chk("a_fwd3", {fwd_a[0], fwd_b[0]}, 0);
    tick();
    #1 chk("a_drain", out_valid[0], 0);

    // producer r5 on unit 1, dependent consumer on src_a
    put(1, 32'hA0, 0, 0, 0, 0, 5'd5, 1, 0, 0, 2'd1);
    tick();
    put(1, 32'hB0, 5'd5, 1, 0, 0, 0, 0, 0, 0, 2'd2);
    #1 chk("b_claim", en_a[0], 1);
    chk("b_waddr", waddr_a[0], 5);
    chk("b_regunit", regunit[0], 1);
    chk("b_accept", in_ready[0], 1);
    tick();
    in_valid = 1'b0;
    #1 chk("b_sb_addr", addr_a[0], 5);
    for (int i = 0; i < 4; i++) begin
      sba(1, 2'd1, rows[i]);
      #1;
      for (int g = 0; g < 2; g++) begin
        chk("b_stall_noclaim", en_a[g], 0);
        chk("b_stall_ready", in_ready[g], 0);
      end
      tick();
    end
    sba(1, 2'd1, 5'b00001);
    #1 chk("b_fwd_issue", in_ready[0], 1);
    chk("b_nofwd_wait", in_ready[1], 0);
    chk("b_nofwd_noclaim", en_a[1], 0);
    tick();
    sba(0, 2'd0, 5'd0);
    #1 chk("b_out_valid", out_valid[0], 1);
    chk("b_out_pay", out_payload[0], 32'hB0);
    chk("b_out_unit", out_unit[0], 2);
    chk("b_out_fwd_a", fwd_a[0], 1);
    chk("b_stall_cnt0", stall[0], 4);
    chk("b_late_issue", in_ready[1], 1);
    tick();
    #1 chk("b_m_valid", out_valid[1], 1);
    chk("b_m_pay", out_payload[1], 32'hB0);
    chk("b_m_fwd_a", fwd_a[1], 0);
    chk("b_stall_cnt1", stall[1], 5);
    tick();

    // r0 source and r0 destination
    put(1, 32'hD0, 0, 0, 0, 1, 0, 1, 0, 0, 2'd3);
    sbb(1, 2'd1, 5'b10000);
    tick();
    in_valid = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("c_issue", in_ready[g], 1);
      chk("c_no_en_a", en_a[g], 0);
      chk("c_no_en_b", en_b[g], 0);
    end
    tick();
    #1 chk("c_valid", out_valid[0], 1);
    chk("c_pay", out_payload[0], 32'hD0);
    chk("c_stall", stall[0], 4);
    sbb(0, 2'd0, 5'd0);
    tick();

    // backpressure then flush
    out_ready = 1'b0;
    put(1, 32'hC1, 0, 0, 0, 0, 5'd6, 1, 0, 0, 2'd0);
    tick();
    put(1, 32'hC2, 0, 0, 0, 0, 5'd7, 1, 0, 0, 2'd0);
    #1 chk("d_en1", en_a[0], 1);
    chk("d_waddr1", waddr_a[0], 6);
    tick();
    put(1, 32'hC3, 0, 0, 0, 0, 5'd8, 1, 0, 0, 2'd0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("d_pay_stable", out_payload[0], 32'hC1);
      chk("d_in_ready", in_ready[0], 0);
      chk("d_no_claim", en_a[0], 0);
      tick();
    end
    flush = 1'b1;
    #1 chk("d_flush_noclaim", en_a[0], 0);
    chk("d_flush_ready", in_ready[0], 0);
    chk("d_stall3", stall[0], 7);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1 chk("d_flush_valid", out_valid[0], 0);
    chk("d_flush_empty", in_ready[0], 1);
    chk("d_stall_hold0", stall[0], 7);
    chk("d_stall_hold1", stall[1], 8);

    // async reset while HELD with out_valid set
    put(1, 32'hE1, 0, 0, 0, 0, 5'd9, 1, 0, 0, 2'd0);
    tick();
    put(1, 32'hE2, 0, 0, 0, 0, 5'd10, 1, 0, 0, 2'd0);
    tick();
    in_valid = 1'b0;
    #1 chk("e_pre_valid", out_valid[0], 1);
    chk("e_pre_held", in_ready[0], 0);
    #2 reset = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("e_valid", out_valid[g], 0);
      chk("e_ready", in_ready[g], 1);
      chk("e_stall", stall[g], 0);
      chk("e_en_a", en_a[g], 0);
    end
    tick();
    chk("e_hold_en", en_a[0], 0);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    #1 chk("e_post_ready", in_ready[0], 1);
    chk("e_post_valid", out_valid[0], 0);
    chk("e_post_en", en_a[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
